// File: rtl/seq_datapath.sv
// seq_datapath: multi-cycle register-file datapath (MOVI/MOV/ALU/CMP) driven by a 5-state FSM.
// Optional build macro: SEQ_DATAPATH_REGFILE_RESET_EN -- when defined, reset also clears the register file.
module seq_datapath #(
    parameter int unsigned W  = 16,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rn,
    input  logic [AW-1:0] rm,
    input  logic [1:0]    shift,
    input  logic [1:0]    aluop,
    input  logic [W-1:0]  imm,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  datapath_out,
    output logic [2:0]    status,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    localparam int unsigned NREGS = 2 ** AW;

    localparam logic [1:0] MODE_MOVI = 2'b00;
    localparam logic [1:0] MODE_MOV  = 2'b01;
    localparam logic [1:0] MODE_CMP  = 2'b11;

    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

    state_t state_q, state_d;

    logic [1:0]    cmd_mode;
    logic [AW-1:0] cmd_rd, cmd_rn, cmd_rm;
    logic [1:0]    cmd_shift, cmd_aluop;

    logic [W-1:0]  reg_a, reg_b, reg_c;
    logic [W-1:0]  regs [NREGS];

    logic          accept_c;
    logic          wr_c;
    logic [W-1:0]  b_sh_c;
    logic [W-1:0]  result_c;
    logic          v_c;

    assign accept_c     = (state_q == IDLE) && start;
    assign wr_c         = (state_q == WB) && (cmd_mode != MODE_CMP);
    assign datapath_out = reg_c;
    assign dbg_data     = regs[dbg_addr];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; MOVI skips the operand reads and goes straight to write-back
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (mode == MODE_MOVI) ? WB : RDA;
            RDA:  state_d = RDB;
            RDB:  state_d = EXEC;
            EXEC: state_d = WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture on the accepting edge so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_mode  <= '0;
            cmd_rd    <= '0;
            cmd_rn    <= '0;
            cmd_rm    <= '0;
            cmd_shift <= '0;
            cmd_aluop <= '0;
        end else if (accept_c) begin
            cmd_mode  <= mode;
            cmd_rd    <= rd;
            cmd_rn    <= rn;
            cmd_rm    <= rm;
            cmd_shift <= shift;
            cmd_aluop <= aluop;
        end
    end

    // Operand-B shifter, ALU and flag generation
    always_comb begin
        b_sh_c   = reg_b;
        result_c = '0;
        v_c      = 1'b0;
        case (cmd_shift)
            SH_LSL1: b_sh_c = {reg_b[W-2:0], 1'b0};
            SH_LSR1: b_sh_c = {1'b0, reg_b[W-1:1]};
            SH_ASR1: b_sh_c = {reg_b[W-1], reg_b[W-1:1]};
            default: b_sh_c = reg_b;
        endcase
        case (cmd_aluop)
            OP_ADD: begin
                result_c = reg_a + b_sh_c;
                v_c = (reg_a[W-1] == b_sh_c[W-1]) && (result_c[W-1] != reg_a[W-1]);
            end
            OP_SUB: begin
                result_c = reg_a - b_sh_c;
                v_c = (reg_a[W-1] != b_sh_c[W-1]) && (result_c[W-1] != reg_a[W-1]);
            end
            OP_AND:  result_c = reg_a & b_sh_c;
            OP_MVN:  result_c = ~b_sh_c;
            default: result_c = '0;
        endcase
        if (cmd_mode == MODE_MOV) begin
            result_c = b_sh_c;
            v_c      = 1'b0;
        end
    end

    // Operand, result and status registers; MOV/MOVI leave status alone
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_c  <= '0;
            status <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept_c && (mode == MODE_MOVI)) reg_c <= imm;
                RDA:  reg_a <= regs[cmd_rn];
                RDB:  reg_b <= regs[cmd_rm];
                EXEC: begin
                    reg_c <= result_c;
                    if (cmd_mode != MODE_MOV) status <= {v_c, result_c[W-1], (result_c == '0)};
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs: busy mirrors the next state, done pulses on leaving WB
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_q == WB);
        end
    end

    // Register file write-back (CMP never writes)
`ifdef SEQ_DATAPATH_REGFILE_RESET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (wr_c) begin
            regs[cmd_rd] <= reg_c;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset && wr_c) regs[cmd_rd] <= reg_c;
    end
`endif

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: vector table + scoreboard, plus hand-written
// sequences for start-while-busy, reset abort, reset-vs-start priority and regfile reset.
module tb_seq_datapath;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [1:0]    mode, shift, aluop;
    logic [AW-1:0] rd, rn, rm, dbg_addr;
    logic [W-1:0]  imm;
    logic          busy, done;
    logic [W-1:0]  datapath_out, dbg_data;
    logic [2:0]    status;

    seq_datapath #(.W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .rd(rd), .rn(rn), .rm(rm), .shift(shift), .aluop(aluop), .imm(imm),
        .busy(busy), .done(done), .datapath_out(datapath_out), .status(status),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  rd, rn, rm;
        logic [1:0]  shift, aluop;
        logic [15:0] imm;
        logic [15:0] exp_out;
        logic [2:0]  exp_st;
        logic [15:0] exp_rd_val;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [2:0]  st;
        logic [2:0]  rd;
        logic [15:0] rd_val;
        int          lat;
    } exp_t;

    localparam int NV = 14;
    vec_t        vecs [NV];
    exp_t        sb [$];
    logic [15:0] shadow [8];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one command (caller sits in the low clock phase), then wait for done and score it
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   lat;
        bit   got;
        mode = v.mode; rd = v.rd; rn = v.rn; rm = v.rm;
        shift = v.shift; aluop = v.aluop; imm = v.imm;
        start = 1'b1;
        sb.push_back('{v.exp_out, v.exp_st, v.rd, v.exp_rd_val, v.exp_lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'($urandom); rd = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom);
        shift = 2'($urandom); aluop = 2'($urandom); imm = 16'($urandom);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) check($sformatf("busy_v%0d", idx), 32'(busy), 32'd1);
            if (done) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_v%0d: no done within 20 cycles, expected latency %0d", idx, e.lat);
        end else begin
            check($sformatf("lat_v%0d", idx), 32'(lat), 32'(e.lat));
            check($sformatf("out_v%0d", idx), 32'(datapath_out), 32'(e.out));
            check($sformatf("status_v%0d", idx), 32'(status), 32'(e.st));
            check($sformatf("busy_done_v%0d", idx), 32'(busy), 32'd0);
            dbg_addr = e.rd;
            #1;
            check($sformatf("rd_val_v%0d", idx), 32'(dbg_data), 32'(e.rd_val));
        end
    endtask

    initial begin
        int ndone;

        //          mode  rd    rn    rm    shift  aluop  imm       out       st      rd_val    lat
        vecs[0]  = '{2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 16'h0007, 16'h0007, 3'b000, 16'h0007, 2};
        vecs[1]  = '{2'b00, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 16'h0002, 16'h0002, 3'b000, 16'h0002, 2};
        vecs[2]  = '{2'b10, 3'd2, 3'd1, 3'd0, 2'b01, 2'b00, 16'h0000, 16'h0010, 3'b000, 16'h0010, 5};
        vecs[3]  = '{2'b11, 3'd1, 3'd1, 3'd1, 2'b00, 2'b01, 16'h0000, 16'h0000, 3'b001, 16'h0002, 5};
        vecs[4]  = '{2'b00, 3'd3, 3'd0, 3'd0, 2'b00, 2'b00, 16'h7FFF, 16'h7FFF, 3'b001, 16'h7FFF, 2};
        vecs[5]  = '{2'b00, 3'd5, 3'd0, 3'd0, 2'b00, 2'b00, 16'h0001, 16'h0001, 3'b001, 16'h0001, 2};
        vecs[6]  = '{2'b10, 3'd4, 3'd3, 3'd5, 2'b00, 2'b00, 16'h0000, 16'h8000, 3'b110, 16'h8000, 5};
        vecs[7]  = '{2'b00, 3'd6, 3'd0, 3'd0, 2'b00, 2'b00, 16'h8004, 16'h8004, 3'b110, 16'h8004, 2};
        vecs[8]  = '{2'b01, 3'd7, 3'd6, 3'd6, 2'b11, 2'b00, 16'h0000, 16'hC002, 3'b110, 16'hC002, 5};
        vecs[9]  = '{2'b10, 3'd2, 3'd2, 3'd0, 2'b00, 2'b01, 16'h0000, 16'h0009, 3'b000, 16'h0009, 5};
        vecs[10] = '{2'b10, 3'd0, 3'd3, 3'd6, 2'b10, 2'b10, 16'h0000, 16'h4002, 3'b000, 16'h4002, 5};
        vecs[11] = '{2'b10, 3'd5, 3'd5, 3'd5, 2'b01, 2'b11, 16'h0000, 16'hFFFD, 3'b010, 16'hFFFD, 5};
        vecs[12] = '{2'b10, 3'd1, 3'd1, 3'd4, 2'b00, 2'b01, 16'h0000, 16'h8002, 3'b110, 16'h8002, 5};
        vecs[13] = '{2'b11, 3'd3, 3'd3, 3'd5, 2'b00, 2'b00, 16'h0000, 16'h7FFC, 3'b000, 16'h7FFF, 5};

        reset = 1'b1; start = 1'b0; mode = '0; rd = '0; rn = '0; rm = '0;
        shift = '0; aluop = '0; imm = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(datapath_out), 32'd0);
        check("rst_status", 32'(status), 32'd0);

        // Each command starts in the done cycle of the previous one
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
            if (vecs[i].mode != 2'b11) shadow[vecs[i].rd] = vecs[i].exp_rd_val;
        end

        // Start pulsed during RDB is dropped: ADD R2,R0,R0 and a stray MOVI R7
        @(negedge clk);
        mode = 2'b10; rd = 3'd2; rn = 3'd0; rm = 3'd0; shift = 2'b00; aluop = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; mode = 2'b00; rd = 3'd7; imm = 16'hDEAD;
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("busy_out", 32'(datapath_out), 32'h8004);
                    check("busy_status", 32'(status), 32'b110);
                end
            end
        end
        check("busy_ndone", 32'(ndone), 32'd1);
        shadow[2] = 16'h8004;
        dbg_addr = 3'd7; #1;
        check("busy_r7", 32'(dbg_data), 32'hC002);
        dbg_addr = 3'd2; #1;
        check("busy_r2", 32'(dbg_data), 32'h8004);

        // Reset during EXEC of SUB R6,R0,R5 aborts without write or done
        @(negedge clk);
        mode = 2'b10; rd = 3'd6; rn = 3'd0; rm = 3'd5; shift = 2'b00; aluop = 2'b01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", 32'(datapath_out), 32'd0);
        check("abort_status", 32'(status), 32'd0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_ndone", 32'(ndone), 32'd0);
        dbg_addr = 3'd6; #1;
        check("abort_r6", 32'(dbg_data), 32'h8004);

        // Reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; mode = 2'b00; rd = 3'd7; imm = 16'h1234;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("prio_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("prio_ndone", 32'(ndone), 32'd0);

        // Register file after the resets above
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
`ifdef SEQ_DATAPATH_REGFILE_RESET_EN
            check($sformatf("rf_r%0d", i), 32'(dbg_data), 32'd0);
`else
            check($sformatf("rf_r%0d", i), 32'(dbg_data), 32'(shadow[i]));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
